sequence_presenter: RTL and testbench

//   Transmit side of the sequence game: plays a computer sequence to the player by showing

---
 rtl/sequence_pkg.sv | 23 ++
 rtl/sequence_presenter_if.sv | 28 ++
 rtl/step_timer.sv | 23 ++
 rtl/sequence_presenter.sv | 136 +++++++++++++
 tb/tb_sequence_presenter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/sequence_pkg.sv
// Shared types and constants for the sequence presenter.
package sequence_pkg;

  localparam int unsigned PAT_W          = 8;
  localparam int unsigned MAX_LEN        = 8;
  localparam int unsigned ON_CYCLES_DEF  = 4;
  localparam int unsigned OFF_CYCLES_DEF = 2;

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } presenter_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequence_presenter_if.sv
// Presenter bus: control in (start/abort/len), generator lookup (pat_idx/pat_data),
// display and status out (led/busy/done).
//   master: drives start, abort, len, pat_data; observes pat_idx, led, busy, done
//   slave : the presenter itself
interface sequence_presenter_if
  import sequence_pkg::*;
  ();

  logic             start;
  logic             abort;
  logic [LEN_W-1:0] len;
  logic [IDX_W-1:0] pat_idx;
  logic [PAT_W-1:0] pat_data;
  logic [PAT_W-1:0] led;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, len, pat_data,
    input  pat_idx, led, busy, done
  );

  modport slave (
    input  start, abort, len, pat_data,
    output pat_idx, led, busy, done
  );

endinterface

// File: rtl/step_timer.sv
// Loadable down-counter that stops at zero.
//   clk, reset (async active-low), load/load_val: reload, zero_c: count is zero
module step_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                count_q <= '0;
    else if (load)             count_q <= load_val;
    else if (count_q != '0)    count_q <= count_q - W'(1);
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/sequence_presenter.sv
// Plays a sequence of patterns on the LEDs: each shown ON_CYCLES clocks, then
// blanked OFF_CYCLES clocks; pulses done after the last gap.
//   clk, reset (async active-low), bus: sequence_presenter_if.slave
module sequence_presenter
  import sequence_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
  parameter int unsigned OFF_CYCLES = OFF_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_presenter_if.slave  bus
);

  localparam int unsigned TMR_W = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  presenter_state_t state_q, state_d;
  logic [PAT_W-1:0] led_q, led_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             more_q, more_d;
  logic             busy_q, done_q;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  step_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, datapath next values, timer reload on every state entry.
  // The index advances on gap entry so pat_data for the next step is settled
  // by the time the gap ends; more_q remembers whether another step follows.
  always_comb begin
    state_d  = state_q;
    led_d    = '0;
    idx_d    = idx_q;
    len_d    = len_q;
    more_d   = more_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (bus.start && !bus.abort) begin
          if (bus.len != '0) begin
            len_d   = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
            led_d   = bus.pat_data;
            state_d = SHOW;
          end else begin
            len_d   = '0;
            state_d = DONE;
          end
        end
      end
      SHOW: begin
        led_d = led_q;
        if (bus.abort) begin
          led_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (tmr_zero) begin
          led_d   = '0;
          state_d = GAP;
          if (LEN_W'(idx_q) != len_q - LEN_W'(1)) begin
            idx_d  = idx_q + IDX_W'(1);
            more_d = 1'b1;
          end else begin
            more_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (tmr_zero) begin
          if (more_q) begin
            led_d   = bus.pat_data;
            state_d = SHOW;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      tmr_load = 1'b1;
      if (state_d == SHOW)     tmr_val = TMR_W'(ON_CYCLES - 1);
      else if (state_d == GAP) tmr_val = TMR_W'(OFF_CYCLES - 1);
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      more_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      more_q <= more_d;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.led     = led_q;
  assign bus.pat_idx = idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_sequence_presenter.sv
// Directed bench for sequence_presenter; generator returns 8'h01 << idx.
module tb_sequence_presenter;
  import sequence_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  sequence_presenter_if bus ();

  assign bus.pat_data = PAT_W'(1) << bus.pat_idx;

  sequence_presenter #(.ON_CYCLES(4), .OFF_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected LED for cycle c of an n-step playback (4 on, 2 off per step)
  function automatic logic [7:0] exp_led(input int n, input int c);
    logic [7:0] one;
    one = 8'h01;
    if (c >= 1 && c <= n * 6 && ((c - 1) % 6) < 4) return one << ((c - 1) / 6);
    return 8'h00;
  endfunction

  task automatic chk_cycle(input string tag, input int n, input int c);
    chk({tag, "_led"},  32'(bus.led),  32'(exp_led(n, c)));
    chk({tag, "_busy"}, 32'(bus.busy), (c >= 1 && c <= n * 6 + 1) ? 32'd1 : 32'd0);
    chk({tag, "_done"}, 32'(bus.done), (c == n * 6 + 1) ? 32'd1 : 32'd0);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_led"},  32'(bus.led),     32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),    32'd0);
    chk({tag, "_done"}, 32'(bus.done),    32'd0);
    chk({tag, "_idx"},  32'(bus.pat_idx), 32'd0);
  endtask

  task automatic kick(input logic [3:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    step();
    bus.start = 1'b0;
  endtask

  logic [7:0] t1_led [1:20];

  initial begin
    t1_led = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
               8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00,
               8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00,
               8'h00, 8'h00};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.len   = '0;
    #12;
    idle_check("reset");
    step();
    reset = 1'b1;
    step();
    idle_check("post_reset");

    // 1: len=3, hand table
    kick(4'd3);
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("t1_led_c%0d", c),  32'(bus.led),  32'(t1_led[c]));
      chk($sformatf("t1_busy_c%0d", c), 32'(bus.busy), (c <= 19) ? 32'd1 : 32'd0);
      chk($sformatf("t1_done_c%0d", c), 32'(bus.done), (c == 19) ? 32'd1 : 32'd0);
      step();
    end

    // 2: len=0 goes straight to DONE
    kick(4'd0);
    chk("t2_done", 32'(bus.done),    32'd1);
    chk("t2_busy", 32'(bus.busy),    32'd1);
    chk("t2_led",  32'(bus.led),     32'd0);
    chk("t2_idx",  32'(bus.pat_idx), 32'd0);
    step();
    idle_check("t2_after");

    // 3: len=12 clamps to 8 steps, done at cycle 49
    kick(4'd12);
    for (int c = 1; c <= 50; c++) begin
      chk_cycle($sformatf("t3_c%0d", c), 8, c);
      step();
    end

    // 4: start while busy is ignored
    kick(4'd2);
    for (int c = 1; c <= 14; c++) begin
      chk_cycle($sformatf("t4_c%0d", c), 2, c);
      if (c == 8) begin
        bus.start = 1'b1;
        bus.len   = 4'd5;
      end
      step();
      bus.start = 1'b0;
    end

    // 5: abort in cycle 9 of a 4-step playback
    kick(4'd4);
    for (int c = 1; c <= 9; c++) begin
      chk_cycle($sformatf("t5_c%0d", c), 4, c);
      if (c == 9) bus.abort = 1'b1;
      step();
    end
    bus.abort = 1'b0;
    for (int c = 10; c <= 27; c++) begin
      idle_check($sformatf("t5_c%0d", c));
      step();
    end

    // abort and start together in IDLE: abort wins
    bus.abort = 1'b1;
    kick(4'd3);
    bus.abort = 1'b0;
    idle_check("abort_start");
    step();
    idle_check("abort_start_2");

    // 6: async reset mid-playback, then a 1-step playback
    kick(4'd4);
    for (int c = 1; c <= 5; c++) begin
      chk_cycle($sformatf("t6_c%0d", c), 4, c);
      step();
    end
    chk_cycle("t6_c6", 4, 6);
    #3;
    reset = 1'b0;
    #1;
    idle_check("t6_async");
    step();
    step();
    reset = 1'b1;
    step();
    idle_check("t6_release");
    kick(4'd1);
    for (int c = 1; c <= 8; c++) begin
      chk_cycle($sformatf("t6b_c%0d", c), 1, c);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
